// File: rtl/pwl_sampler_if.sv
// Sampler bus: pwl input {a, b, t0}, enable, and the result FIFO valid/ready head.
// master = the sampler (produces results), slave = the driver/consumer of the sampler.
interface pwl_sampler_if #(
  parameter int unsigned NBIT = 8
);
  timeunit 1ns;
  timeprecision 1ps;

  real              in_a;
  real              in_b;
  real              in_t0;
  logic             en;
  logic             ready;
  logic [NBIT-1:0]  out_code;
  real              out_real;
  logic             valid;
  logic             ovf;

  modport master (
    input  in_a, in_b, in_t0, en, ready,
    output out_code, out_real, valid, ovf
  );

  modport slave (
    output in_a, in_b, in_t0, en, ready,
    input  out_code, out_real, valid, ovf
  );
endinterface

// File: rtl/pwl_sampler.sv
// Clocked pwl-to-digital receiver: samples a pwl input at each edge, block-averages
// NAVG samples, quantizes to NBIT and queues {code, avg} in a DEPTH-entry FIFO.
module pwl_sampler #(
  parameter int unsigned NBIT  = 8,
  parameter int unsigned NAVG  = 4,
  parameter int unsigned DEPTH = 4,
  parameter real         vmin  = 0.0,
  parameter real         vmax  = 1.0
) (
  input logic           clk,
  input logic           rst,
  pwl_sampler_if.master bus
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FCNT_W   = PTR_W + 1;
  localparam int unsigned CNT_W    = (NAVG > 1) ? $clog2(NAVG) : 1;
  localparam int unsigned CODE_MAX = (1 << NBIT) - 1;
  localparam real         SCALE    = real'(CODE_MAX + 1);
  // pwl times are in seconds; simulation time runs in ns
  localparam real         TIME_SCALE = 1.0e-9;

  logic [CNT_W-1:0]  cnt;
  real               acc;
  logic [NBIT-1:0]   code_mem [DEPTH];
  real               real_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_next;
  logic [FCNT_W-1:0] count;
  logic [FCNT_W-1:0] remain;
  logic [FCNT_W-1:0] count_next;
  logic              pop;
  logic              full;
  logic              block_done;
  logic              do_push;
  logic              drop;
  logic              head_from_push;

  function automatic real pwl_eval(input real a, input real b, input real t0);
    return a + b * ($realtime * TIME_SCALE - t0);
  endfunction

  function automatic real block_avg(input real acc_v, input real sample_v);
    return (acc_v + sample_v) / real'(NAVG);
  endfunction

  // Saturating floor quantizer; the SCALE guard catches rounding just below vmax
  function automatic logic [NBIT-1:0] quantize(input real v);
    real x;
    x = (v - vmin) / (vmax - vmin) * SCALE;
    if (v >= vmax)      return NBIT'(CODE_MAX);
    else if (v < vmin)  return '0;
    else if (x >= SCALE) return NBIT'(CODE_MAX);
    else                return NBIT'($rtoi(x));
  endfunction

  // FIFO control: pop precedes push so a full FIFO can accept on a pop edge
  always_comb begin
    pop            = bus.valid && bus.ready;
    full           = (count == FCNT_W'(DEPTH));
    block_done     = bus.en && (cnt == CNT_W'(NAVG - 1));
    do_push        = block_done && (!full || pop);
    drop           = block_done && full && !pop;
    remain         = count - FCNT_W'(pop);
    count_next     = remain + FCNT_W'(do_push);
    rd_next        = rd_ptr + PTR_W'(pop);
    head_from_push = do_push && (remain == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      acc          <= 0.0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.valid    <= 1'b0;
      bus.ovf      <= 1'b0;
      bus.out_code <= '0;
      bus.out_real <= 0.0;
    end else begin
      // a disabled edge discards the partial block
      if (!bus.en || block_done) begin
        cnt <= '0;
        acc <= 0.0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        acc <= acc + pwl_eval(bus.in_a, bus.in_b, bus.in_t0);
      end

      if (do_push) begin
        code_mem[wr_ptr] <= quantize(block_avg(acc, pwl_eval(bus.in_a, bus.in_b, bus.in_t0)));
        real_mem[wr_ptr] <= block_avg(acc, pwl_eval(bus.in_a, bus.in_b, bus.in_t0));
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end

      if (drop) bus.ovf <= 1'b1;

      rd_ptr    <= rd_next;
      count     <= count_next;
      bus.valid <= (count_next != '0);

      // head shows the entry at the front after this edge; hold when empty
      if (head_from_push) begin
        bus.out_code <= quantize(block_avg(acc, pwl_eval(bus.in_a, bus.in_b, bus.in_t0)));
        bus.out_real <= block_avg(acc, pwl_eval(bus.in_a, bus.in_b, bus.in_t0));
      end else if (remain != '0) begin
        bus.out_code <= code_mem[rd_next];
        bus.out_real <= real_mem[rd_next];
      end
    end
  end
endmodule
